// File: rtl/chi_link_pkg.sv
// Shared CHI link-layer types and constants: link FSM states, link-flit opcode,
// per-channel opcode field positions and a saturating counter helper.
package chi_link_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      ACT   = 2'd1,
      RUN   = 2'd2,
      DEACT = 2'd3
   } link_state_e;

   // Opcode value that marks a link (credit-return) flit on any channel
   localparam logic [7:0] LINK_FLIT_OPC = 8'h00;

   localparam int REQ_OPC_LEFT  = 20;
   localparam int REQ_OPC_RIGHT = 14;
   localparam int RSP_OPC_LEFT  = 17;
   localparam int RSP_OPC_RIGHT = 14;
   localparam int SNP_OPC_LEFT  = 18;
   localparam int SNP_OPC_RIGHT = 14;
   localparam int DAT_OPC_LEFT  = 17;
   localparam int DAT_OPC_RIGHT = 14;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return value;
      end else begin
         return value + 8'd1;
      end
   endfunction

endpackage

// File: rtl/chi_link_rx_port_fifo.sv
// Generic register-based FIFO with optional write/read enable gating, plus its
// simulation checker that flags a push into a full buffer without a pop.
module chi_link_rx_port_fifo
   import chi_link_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 4,
   parameter int CNT_W        = 4,
   parameter int CLOCK_ENABLE = 0
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             cg_en,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic             full,
   output logic [CNT_W-1:0] cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CNT_W-1:0] cnt_r;
   logic             en_s;
   logic             empty_s;
   logic             full_s;
   logic             wr_s;
   logic             rd_s;

   assign en_s    = (CLOCK_ENABLE == 0) || cg_en;
   assign empty_s = (cnt_r == {CNT_W{1'b0}});
   assign full_s  = (cnt_r == CNT_W'(DEPTH));
   // A full buffer may still take a push when the head leaves in the same cycle
   assign rd_s    = en_s && pop && !empty_s;
   assign wr_s    = en_s && push && (!full_s || rd_s);

   assign pop_data = mem_r[rd_ptr_r];
   assign valid    = !empty_s;
   assign full     = full_s;
   assign cnt      = cnt_r;

   // Storage, pointers and occupancy
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         if (wr_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
         end
         if (rd_s) begin
            rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
         end
         case ({wr_s, rd_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   chi_link_rx_port_fifo_chk u_chk (
      .clock (clock),
      .rstn  (rstn),
      .push  (push),
      .pop   (rd_s),
      .full  (full_s)
   );

endmodule

module chi_link_rx_port_fifo_chk (
   input logic clock,
   input logic rstn,
   input logic push,
   input logic pop,
   input logic full
);

   property p_no_push_on_full;
      @(posedge clock) disable iff (!rstn) !(push && full && !pop);
   endproperty

   a_no_push_on_full: assert property (p_no_push_on_full);

endmodule

// File: rtl/chi_link_rx_port.sv
// CHI link RX port: activation FSM, L-credit issue, flit decode and buffering.
// Build option CHI_RX_ERR_CNT_EN adds a saturating protocol-error counter.
module chi_link_rx_port
   import chi_link_pkg::*;
#(
   parameter int FLIT_WIDTH    = 8,
   parameter int RX_FIFO_DEPTH = 4,
   parameter int OPC_LEFT      = 7,
   parameter int OPC_RIGHT     = 4,
   parameter int CRD_W         = 4
) (
   input  logic                  clock,
   input  logic                  rstn,
   input  logic                  rxlinkactivereq,
   output logic                  rxlinkactiveack,
   input  logic                  rx_flitpend,
   input  logic                  rx_flitv,
   input  logic [FLIT_WIDTH-1:0] rx_flit,
   output logic                  rxlcrdv,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic [CRD_W-1:0]      crd_outstanding,
   output logic                  link_idle,
   output logic                  proto_err,
   output logic [7:0]            err_cnt
);

   localparam int OPC_W = OPC_LEFT - OPC_RIGHT + 1;

   link_state_e      state_r;
   link_state_e      state_ns;
   logic [CRD_W-1:0] crd_r;
   logic [CRD_W-1:0] crd_ns;
   logic [CRD_W-1:0] fifo_cnt_s;
   logic [OPC_W-1:0] opc_s;
   logic             ack_r;
   logic             pend_prev_r;
   logic             err_r;
   logic             lcrdv_s;
   logic             acc_s;
   logic             err_s;
   logic             push_s;
   logic             pop_s;
   logic             fifo_valid_s;
   logic             fifo_full_s;

   assign opc_s = rx_flit[OPC_LEFT:OPC_RIGHT];

   // Only register state feeds the grant, so a pop frees its slot one cycle later
   assign lcrdv_s = (state_r == RUN) &&
                    (({1'b0, crd_r} + {1'b0, fifo_cnt_s}) < (CRD_W + 1)'(RX_FIFO_DEPTH));
   assign acc_s   = rx_flitv && (crd_r != {CRD_W{1'b0}}) && (state_r != STOP);
   assign err_s   = rx_flitv && ((crd_r == {CRD_W{1'b0}}) || (state_r == STOP) || !pend_prev_r);
   assign push_s  = acc_s && !err_s && (opc_s != OPC_W'(LINK_FLIT_OPC));
   assign pop_s   = fifo_valid_s && out_ready;

   // Next link state
   always_comb begin
      state_ns = state_r;
      case (state_r)
         STOP:    state_ns = rxlinkactivereq ? ACT : STOP;
         ACT:     state_ns = rxlinkactivereq ? RUN : STOP;
         RUN:     state_ns = rxlinkactivereq ? RUN : DEACT;
         DEACT: begin
            if ((crd_r == {CRD_W{1'b0}}) && !lcrdv_s) begin
               state_ns = STOP;
            end else begin
               state_ns = DEACT;
            end
         end
         default: state_ns = STOP;
      endcase
   end

   // Outstanding-credit count; grant and accept together cancel out
   always_comb begin
      crd_ns = crd_r;
      if (lcrdv_s && !acc_s) begin
         crd_ns = crd_r + CRD_W'(1);
      end else if (acc_s && !lcrdv_s) begin
         crd_ns = crd_r - CRD_W'(1);
      end else begin
         crd_ns = crd_r;
      end
   end

   // Link state, credits, acknowledge and error tracking registers
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_r     <= STOP;
         crd_r       <= {CRD_W{1'b0}};
         ack_r       <= 1'b0;
         pend_prev_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_ns;
         crd_r       <= crd_ns;
         ack_r       <= (state_ns == RUN) || (state_ns == DEACT);
         pend_prev_r <= rx_flitpend;
         err_r       <= err_r || err_s;
      end
   end

`ifdef CHI_RX_ERR_CNT_EN
   logic [7:0] err_cnt_r;

   // Saturating protocol-error counter
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         err_cnt_r <= 8'd0;
      end else if (err_s) begin
         err_cnt_r <= sat_inc8(err_cnt_r);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = 8'd0;
`endif

   chi_link_rx_port_fifo #(
      .WIDTH        (FLIT_WIDTH),
      .DEPTH        (RX_FIFO_DEPTH),
      .CNT_W        (CRD_W),
      .CLOCK_ENABLE (0)
   ) u_rx_fifo (
      .clock     (clock),
      .rstn      (rstn),
      .cg_en     (1'b1),
      .push      (push_s),
      .push_data (rx_flit),
      .pop       (pop_s),
      .pop_data  (out_flit),
      .valid     (fifo_valid_s),
      .full      (fifo_full_s),
      .cnt       (fifo_cnt_s)
   );

   assign rxlinkactiveack = ack_r;
   assign rxlcrdv         = lcrdv_s;
   assign out_valid       = fifo_valid_s;
   assign crd_outstanding = crd_r;
   assign link_idle       = (state_r == STOP) && !fifo_valid_s;
   assign proto_err       = err_r;

endmodule

// File: tb/tb_chi_link_rx_port.sv
// Directed bench for chi_link_rx_port with a queue-based reference model checked every cycle.
module tb_chi_link_rx_port;

   localparam int DEPTH = 4;
   localparam int P_STOP = 0, P_ACT = 1, P_RUN = 2, P_DEACT = 3;

   logic       clock = 1'b0;
   logic       rstn = 1'b0;
   logic       rxlinkactivereq = 1'b0;
   logic       rxlinkactiveack;
   logic       rx_flitpend = 1'b0;
   logic       rx_flitv = 1'b0;
   logic [7:0] rx_flit = 8'h00;
   logic       rxlcrdv;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_flit;
   logic [3:0] crd_outstanding;
   logic       link_idle;
   logic       proto_err;
   logic [7:0] err_cnt;

   int n_pass = 0;
   int n_total = 0;

   // reference model
   logic [7:0] m_q[$];
   int m_phase = P_STOP;
   int m_crd = 0;
   bit m_pend_prev = 1'b0;
   bit m_err = 1'b0;
   int m_errcnt = 0;

   chi_link_rx_port dut (
      .clock           (clock),
      .rstn            (rstn),
      .rxlinkactivereq (rxlinkactivereq),
      .rxlinkactiveack (rxlinkactiveack),
      .rx_flitpend     (rx_flitpend),
      .rx_flitv        (rx_flitv),
      .rx_flit         (rx_flit),
      .rxlcrdv         (rxlcrdv),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_flit        (out_flit),
      .crd_outstanding (crd_outstanding),
      .link_idle       (link_idle),
      .proto_err       (proto_err),
      .err_cnt         (err_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit m_grant();
      return (m_phase == P_RUN) && (m_crd + m_q.size() < DEPTH);
   endfunction

   // model stepping
   initial begin
      forever begin
         @(posedge clock or negedge rstn);
         if (!rstn) begin
            m_q.delete();
            m_phase = P_STOP; m_crd = 0; m_pend_prev = 1'b0; m_err = 1'b0; m_errcnt = 0;
         end else begin
            bit g, a, e, p;
            int old_crd;
            g = m_grant();
            a = rx_flitv && m_crd != 0 && m_phase != P_STOP;
            e = rx_flitv && (m_crd == 0 || m_phase == P_STOP || !m_pend_prev);
            p = (m_q.size() != 0) && out_ready;
            if (p) void'(m_q.pop_front());
            if (a && !e && rx_flit[7:4] != 4'h0) m_q.push_back(rx_flit);
            old_crd = m_crd;
            m_crd = m_crd + (g ? 1 : 0) - (a ? 1 : 0);
            case (m_phase)
               P_STOP:  if (rxlinkactivereq) m_phase = P_ACT;
               P_ACT:   m_phase = rxlinkactivereq ? P_RUN : P_STOP;
               P_RUN:   if (!rxlinkactivereq) m_phase = P_DEACT;
               default: if (old_crd == 0 && !g) m_phase = P_STOP;
            endcase
            if (e) begin
               m_err = 1'b1;
               if (m_errcnt < 255) m_errcnt++;
            end
            m_pend_prev = rx_flitpend;
         end
      end
   end

   function automatic int exp_errcnt();
`ifdef CHI_RX_ERR_CNT_EN
      return m_errcnt;
`else
      return 0;
`endif
   endfunction

   // every-cycle compare against the model
   initial begin
      forever begin
         @(negedge clock);
         chk("ack", 32'(rxlinkactiveack), 32'(m_phase == P_RUN || m_phase == P_DEACT));
         chk("rxlcrdv", 32'(rxlcrdv), 32'(m_grant()));
         chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) chk("out_flit", 32'(out_flit), 32'(m_q[0]));
         chk("crd", 32'(crd_outstanding), 32'(m_crd));
         chk("link_idle", 32'(link_idle), 32'(m_phase == P_STOP && m_q.size() == 0));
         chk("proto_err", 32'(proto_err), 32'(m_err));
         chk("err_cnt", 32'(err_cnt), 32'(exp_errcnt()));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_ack", 32'(rxlinkactiveack), 32'd0);
      chk("rst_idle", 32'(link_idle), 32'd1);
      chk("rst_crd", 32'(crd_outstanding), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      rstn = 1'b1;
      tick();

      // 1: activation and initial credit burst
      rxlinkactivereq = 1'b1;
      tick(); chk("t1_ack_c1", 32'(rxlinkactiveack), 32'd0);
      tick(); chk("t1_ack_c2", 32'(rxlinkactiveack), 32'd1);
      chk("t1_lcrdv_c2", 32'(rxlcrdv), 32'd1);
      for (int i = 3; i <= 5; i++) begin
         tick(); chk("t1_lcrdv_burst", 32'(rxlcrdv), 32'd1);
      end
      tick(); chk("t1_lcrdv_c6", 32'(rxlcrdv), 32'd0);
      chk("t1_crd4", 32'(crd_outstanding), 32'd4);

      // 2: four data flits fill the buffer, one pop returns one credit
      rx_flitpend = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         rx_flitv = 1'b1; rx_flit = 8'h31 + 8'(i);
         tick();
         if (i == 0) chk("t2_valid_n1", 32'(out_valid), 32'd1);
      end
      rx_flitv = 1'b0;
      chk("t2_crd0", 32'(crd_outstanding), 32'd0);
      chk("t2_no_lcrdv", 32'(rxlcrdv), 32'd0);
      chk("t2_head", 32'(out_flit), 32'h31);
      tick(); chk("t2_no_lcrdv2", 32'(rxlcrdv), 32'd0);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      chk("t2_lcrdv_after_pop", 32'(rxlcrdv), 32'd1);
      chk("t2_head2", 32'(out_flit), 32'h32);
      tick(); chk("t2_single_lcrdv", 32'(rxlcrdv), 32'd0);
      chk("t2_crd1", 32'(crd_outstanding), 32'd1);
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      repeat (4) tick();
      chk("t2_crd_refill", 32'(crd_outstanding), 32'd4);
      chk("t2_empty", 32'(out_valid), 32'd0);

      // 3: link flit consumes a credit without buffering
      rx_flitv = 1'b1; rx_flit = 8'h05;
      tick(); rx_flitv = 1'b0;
      chk("t3_crd3", 32'(crd_outstanding), 32'd3);
      chk("t3_lcrdv", 32'(rxlcrdv), 32'd1);
      chk("t3_no_valid", 32'(out_valid), 32'd0);
      tick(); chk("t3_crd4", 32'(crd_outstanding), 32'd4);
      chk("t3_lcrdv_off", 32'(rxlcrdv), 32'd0);

      // 4: deactivation drains credits with link flits
      rxlinkactivereq = 1'b0;
      tick(); chk("t4_ack_deact", 32'(rxlinkactiveack), 32'd1);
      chk("t4_no_lcrdv", 32'(rxlcrdv), 32'd0);
      for (int i = 0; i < 4; i++) begin
         rx_flitv = 1'b1; rx_flit = 8'h0A;
         tick();
      end
      rx_flitv = 1'b0;
      chk("t4_crd0", 32'(crd_outstanding), 32'd0);
      chk("t4_ack_still", 32'(rxlinkactiveack), 32'd1);
      tick(); chk("t4_ack_off", 32'(rxlinkactiveack), 32'd0);
      chk("t4_idle", 32'(link_idle), 32'd1);

      // 5: flit without credit is a protocol error
      rx_flitv = 1'b1; rx_flit = 8'h3C;
      tick(); rx_flitv = 1'b0;
      chk("t5_proto_err", 32'(proto_err), 32'd1);
      chk("t5_dropped", 32'(out_valid), 32'd0);
`ifdef CHI_RX_ERR_CNT_EN
      chk("t5_err_cnt", 32'(err_cnt), 32'd1);
`else
      chk("t5_err_cnt", 32'(err_cnt), 32'd0);
`endif

      // 6: asynchronous reset with buffered traffic
      rxlinkactivereq = 1'b1;
      repeat (6) tick();
      chk("t6_crd4", 32'(crd_outstanding), 32'd4);
      rx_flitv = 1'b1; rx_flit = 8'h71; tick();
      rx_flit = 8'h72; tick();
      rx_flitv = 1'b0;
      chk("t6_valid", 32'(out_valid), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("t6_valid0", 32'(out_valid), 32'd0);
      chk("t6_ack0", 32'(rxlinkactiveack), 32'd0);
      chk("t6_lcrdv0", 32'(rxlcrdv), 32'd0);
      chk("t6_crd0", 32'(crd_outstanding), 32'd0);
      chk("t6_idle", 32'(link_idle), 32'd1);
      chk("t6_err0", 32'(proto_err), 32'd0);
      rxlinkactivereq = 1'b0;
      tick(); rstn = 1'b1;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
